// File: rtl/mycpu_store_buffer_pkg.sv
// Shared store-path definitions: store-size encodings and drain FSM state codes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mycpu_store_buffer_pkg;

   // Store size field, carried in mode[3:1]
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_WL = 3'b011;
   localparam logic [2:0] SZ_WR = 3'b100;

   // Drain FSM: one outstanding bus write at a time
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } drain_state_e;

endpackage

// File: rtl/mycpu_store_align.sv
// Store alignment: size/offset/data -> lane-aligned byte strobes, write data, misalign flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to queue the result.
module mycpu_store_align
   import mycpu_store_buffer_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int BYTES  = DATA_W / 8,
   localparam int OFF_W  = $clog2(BYTES)
) (
   input  logic [2:0]        size,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] data,
   output logic [BYTES-1:0]  wstrb,
   output logic [DATA_W-1:0] wdata,
   output logic              misalign,
   output logic              legal
);

   logic [1:0]       k;
   logic [OFF_W-1:0] word_base;
   logic [3:0]       word_strb;
   logic [31:0]      word_dat;
   logic [4:0]       shamt;

   // Byte offset within the addressed 32-bit word, and the lane of that word's byte 0
   assign k         = off[1:0];
   assign word_base = off & ~OFF_W'(3);

   // Decode size into strobes/data; WL/WR build a 4-byte pattern then place it on its word
   always_comb begin
      wstrb     = '0;
      wdata     = '0;
      misalign  = 1'b0;
      legal     = 1'b0;
      word_strb = '0;
      word_dat  = '0;
      shamt     = '0;
      case (size)
         SZ_B: begin
            wstrb = BYTES'(1) << off;
            wdata = {BYTES{data[7:0]}};
            legal = 1'b1;
         end
         SZ_H: begin
            wstrb    = BYTES'(3) << off;
            wdata    = {(BYTES/2){data[15:0]}};
            misalign = off[0];
            legal    = 1'b1;
         end
         SZ_W: begin
            wstrb    = BYTES'(15) << off;
            wdata    = {(BYTES/4){data[31:0]}};
            misalign = (k != 2'b00);
            legal    = 1'b1;
         end
         SZ_WL: begin
            // bytes 0..k receive the most significant register bytes
            word_strb = 4'hF >> (2'd3 - k);
            shamt     = {(2'd3 - k), 3'b000};
            word_dat  = data[31:0] >> shamt;
            wstrb     = BYTES'(word_strb) << word_base;
            wdata     = {(BYTES/4){word_dat}};
            legal     = 1'b1;
         end
         SZ_WR: begin
            // bytes k..3 receive the least significant register bytes
            word_strb = 4'hF << k;
            shamt     = {k, 3'b000};
            word_dat  = data[31:0] << shamt;
            wstrb     = BYTES'(word_strb) << word_base;
            wdata     = {(BYTES/4){word_dat}};
            legal     = 1'b1;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mycpu_store_buffer.sv
// MEM-stage store buffer: align stores, queue them in a FIFO, drain over req/addr_ok/data_ok.
// Latency: accepted store reaches mem_req two cycles after acceptance when the FIFO was idle.
// Backpressure: in_ready drops while the FIFO is full; a head entry holds until mem_addr_ok.
module mycpu_store_buffer
   import mycpu_store_buffer_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   parameter  int DEPTH  = 4,
   localparam int BYTES  = DATA_W / 8,
   localparam int OFF_W  = $clog2(BYTES),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_mode,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              ex_ades,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_conflict,
   output logic              empty,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BYTES-1:0]  mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok
);

   logic [BYTES-1:0]  al_wstrb;
   logic [DATA_W-1:0] al_wdata;
   logic              al_misalign;
   logic              al_legal;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [BYTES-1:0]  strb_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   drain_state_e      state_q;
   drain_state_e      state_d;

   logic              accept;
   logic              store_en;
   logic              push;
   logic              pop;
   logic [PTR_W-1:0]  rel   [DEPTH];
   logic [DEPTH-1:0]  hit;
   logic              unused_bits;

   mycpu_store_align #(.DATA_W(DATA_W)) u_align (
      .size     (in_mode[3:1]),
      .off      (in_addr[OFF_W-1:0]),
      .data     (in_data),
      .wstrb    (al_wstrb),
      .wdata    (al_wdata),
      .misalign (al_misalign),
      .legal    (al_legal)
   );

   // Full FIFO refuses new stores even if the head completes this cycle
   assign in_ready = (count != CNT_W'(DEPTH));
   assign accept   = in_valid & in_ready;
   assign store_en = in_mode[4];
   assign push     = accept & store_en & al_legal & ~al_misalign;

   assign mem_addr  = addr_q[rd_ptr];
   assign mem_wstrb = strb_q[rd_ptr];
   assign mem_wdata = data_q[rd_ptr];
   assign empty     = (count == '0) && (state_q == ST_IDLE);

   // Entry storage; the head stays resident until data_ok so conflicts still see it
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         strb_q[wr_ptr] <= al_wstrb;
         data_q[wr_ptr] <= al_wdata;
      end
   end

   // Pointers, occupancy, drain state and the misaligned-store pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         state_q <= ST_IDLE;
         ex_ades <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count   <= count + CNT_W'(push) - CNT_W'(pop);
         state_q <= state_d;
         ex_ades <= accept & store_en & al_misalign;
      end
   end

   // Drain FSM: request the head, wait for completion, then retire it
   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count != '0) state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_req = 1'b1;
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (mem_data_ok) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // An entry is live when its distance from the head is below the occupancy
   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign rel[i] = PTR_W'(i) - rd_ptr;
      assign hit[i] = (CNT_W'(rel[i]) < count) &&
                      (addr_q[i][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]);
   end
   assign ld_conflict = |hit;

   // Byte-offset bits of the load address and unused mode bits do not matter here
   assign unused_bits = ^{ld_addr[OFF_W-1:0], in_mode[5], in_mode[0]};

endmodule

// File: tb/tb_mycpu_store_buffer.sv
// Bench for mycpu_store_buffer: directed scenarios plus random traffic against a queue model.
// Latency: checks are sampled on the falling edge; inputs change 1 time unit after rising edge.
// Backpressure: bus addr_ok/data_ok are driven by the bench to exercise stalls.
module tb_mycpu_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_mode = '0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic        ex_ades;
   logic [31:0] ld_addr = '0;
   logic        ld_conflict;
   logic        empty;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok = 1'b0;
   logic        mem_data_ok = 1'b0;

   always #5 clk = ~clk;

   mycpu_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mode     (in_mode),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .ex_ades     (ex_ades),
      .ld_addr     (ld_addr),
      .ld_conflict (ld_conflict),
      .empty       (empty),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wstrb   (mem_wstrb),
      .mem_wdata   (mem_wdata),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   writes = 0;
   int   stall = 0;
   logic outstanding = 1'b0;
   logic ades_exp = 1'b0;
   logic prev_hold = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Memory-level meaning of each store: which bytes of the word change and to what
   function automatic void ref_align(input logic [2:0] sz, input logic [1:0] off,
                                     input logic [31:0] d, output logic ok, output logic mis,
                                     output logic [3:0] st, output logic [31:0] wd);
      int o;
      o = int'(off);
      ok = 1'b1; mis = 1'b0; st = '0; wd = '0;
      case (sz)
         3'd0: begin
            st[o] = 1'b1;
            for (int j = 0; j < 4; j++) wd[8*j +: 8] = d[7:0];
         end
         3'd1: begin
            mis = off[0];
            if (!mis) begin st[o] = 1'b1; st[o+1] = 1'b1; end
            wd = {d[15:0], d[15:0]};
         end
         3'd2: begin
            mis = (off != 2'd0);
            st = 4'hF;
            wd = d;
         end
         3'd3: begin
            for (int j = 0; j < 4; j++)
               if (j <= o) begin st[j] = 1'b1; wd[8*j +: 8] = d[8*(j+3-o) +: 8]; end
         end
         3'd4: begin
            for (int j = 0; j < 4; j++)
               if (j >= o) begin st[j] = 1'b1; wd[8*j +: 8] = d[8*(j-o) +: 8]; end
         end
         default: ok = 1'b0;
      endcase
   endfunction

   // One clock: check outputs against the model, advance the model, step past the edge
   task automatic tick();
      logic ok, mis, conf;
      logic [3:0] st;
      logic [31:0] wd;
      logic acc;
      ent_t e;
      @(negedge clk);
      conf = 1'b0;
      foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) conf = 1'b1;
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("ex_ades", ex_ades, ades_exp);
      chk("empty", empty, mq.size() == 0);
      chk("ld_conflict", ld_conflict, conf);
      if (prev_hold) chk("req_hold", mem_req, 1'b1);
      if (mem_req) begin
         chk("req_legal", {outstanding, mq.size() == 0}, 32'd0);
         if (mq.size() > 0) begin
            chk("head_addr", mem_addr, {mq[0].addr[31:2], 2'b00});
            chk("head_strb", mem_wstrb, mq[0].strb);
            chk("head_data", mem_wdata, mq[0].data);
         end
      end
      if (mq.size() > 0 && !outstanding && !mem_req) stall++; else stall = 0;
      chk("req_latency", stall > 2, 1'b0);
      if (reset) begin
         mq.delete();
         outstanding = 1'b0;
         ades_exp = 1'b0;
         prev_hold = 1'b0;
         stall = 0;
      end else begin
         acc = in_valid && (mq.size() < DEPTH);
         if (outstanding) begin
            if (mem_data_ok) begin void'(mq.pop_front()); outstanding = 1'b0; writes++; end
         end else if (mem_req && mem_addr_ok) begin
            if (mem_data_ok) begin void'(mq.pop_front()); writes++; end
            else outstanding = 1'b1;
         end
         prev_hold = mem_req && !mem_addr_ok;
         ref_align(in_mode[3:1], in_addr[1:0], in_data, ok, mis, st, wd);
         ades_exp = acc && in_mode[4] && mis;
         if (acc && in_mode[4] && ok && !mis) begin
            e.addr = in_addr; e.strb = st; e.data = wd;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      in_valid = 1'b1;
      in_mode  = {1'b0, 1'b1, sz, 1'b0};
      in_addr  = a;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int w0;
      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_empty", empty, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_ex_ades", ex_ades, 1'b0);

      // SB at byte 3
      push_store(3'd0, 32'h1003, 32'h0000_00AB);
      tick();
      chk("sb_req", mem_req, 1'b1);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_strb", mem_wstrb, 4'b1000);
      chk("sb_data", mem_wdata, 32'hABAB_ABAB);
      mem_addr_ok = 1'b1; tick(); mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1; tick(); mem_data_ok = 1'b0;
      chk("sb_empty", empty, 1'b1);

      // SWL then SWR at 0x2001
      push_store(3'd3, 32'h2001, 32'h1122_3344);
      push_store(3'd4, 32'h2001, 32'h1122_3344);
      chk("swl_strb", mem_wstrb, 4'b0011);
      chk("swl_low", mem_wdata & 32'hFFFF, 32'h1122);
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; tick();
      chk("swr_strb", mem_wstrb, 4'b1110);
      chk("swr_data", mem_wdata, 32'h2233_4400);
      mem_addr_ok = 1'b1; tick(); mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1; tick(); mem_data_ok = 1'b0;

      // Misaligned SW
      push_store(3'd2, 32'h3002, 32'hDEAD_BEEF);
      chk("ades_pulse", ex_ades, 1'b1);
      chk("ades_empty", empty, 1'b1);
      tick();
      chk("ades_clear", ex_ades, 1'b0);
      chk("ades_noreq", mem_req, 1'b0);

      // Fill to DEPTH with the bus stalled, then drain in order
      for (int i = 0; i < DEPTH; i++) push_store(3'd2, 32'h100 + 32'(4*i), 32'h5000 + 32'(i));
      chk("full_ready", in_ready, 1'b0);
      push_store(3'd2, 32'h200, 32'h5555);
      chk("full_still", in_ready, 1'b0);
      w0 = writes;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int c = 0; c < 40 && mq.size() != 0; c++) tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      chk("full_drained", writes - w0, 32'd4);
      chk("full_empty", empty, 1'b1);

      // Load conflict against queued and in-flight head
      ld_addr = 32'h4002;
      push_store(3'd2, 32'h4000, 32'h7777_7777);
      chk("conf_hit", ld_conflict, 1'b1);
      ld_addr = 32'h5000; #1;
      chk("conf_miss", ld_conflict, 1'b0);
      ld_addr = 32'h4002;
      tick();
      mem_addr_ok = 1'b1; tick(); mem_addr_ok = 1'b0;
      chk("conf_inflight", ld_conflict, 1'b1);
      mem_data_ok = 1'b1; tick(); mem_data_ok = 1'b0;
      chk("conf_gone", ld_conflict, 1'b0);
      chk("conf_empty", empty, 1'b1);

      // Reset while a write is in flight with three entries queued
      push_store(3'd2, 32'h600, 32'h1);
      push_store(3'd2, 32'h604, 32'h2);
      push_store(3'd2, 32'h608, 32'h3);
      mem_addr_ok = 1'b1; tick(); mem_addr_ok = 1'b0;
      chk("wait_noreq", mem_req, 1'b0);
      chk("wait_busy", empty, 1'b0);
      reset = 1'b1; tick(); reset = 1'b0;
      ld_addr = 32'h600; #1;
      chk("mrst_req", mem_req, 1'b0);
      chk("mrst_empty", empty, 1'b1);
      chk("mrst_ready", in_ready, 1'b1);
      chk("mrst_conf", ld_conflict, 1'b0);
      tick();
      chk("mrst_idle", mem_req, 1'b0);

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         in_valid    = ($urandom_range(0, 2) != 0);
         in_mode     = {1'($urandom), 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 1'($urandom)};
         in_addr     = 32'h8000 + 32'($urandom_range(0, 31));
         in_data     = $urandom;
         ld_addr     = 32'h8000 + 32'($urandom_range(0, 31));
         mem_addr_ok = 1'($urandom);
         mem_data_ok = 1'($urandom);
         reset       = ($urandom_range(0, 199) == 0);
         tick();
      end
      in_valid = 1'b0; reset = 1'b0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int c = 0; c < 40 && mq.size() != 0; c++) tick();
      tick();
      chk("final_queue", mq.size(), 32'd0);
      chk("final_empty", empty, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
